seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, multi-cycle successor of the datapath ALU; computes Ry op Rb.
//  Single-cycle ops complete in 1 cycle. Signed MUL (shift-add) and signed DIV
//  (non-restoring) are iterative, so the wide combinational multiplier/divider is gone.
//  Sits between the Y/B operand registers and the Z (Zhi/Zlo) register; the control unit drives start/opcode.
// PARAMETERS
//  WIDTH      32  operand width; even, >=4
//  SHAMT_W    5   shift-amount bits taken from Rb[SHAMT_W-1:0]; must equal log2(WIDTH)
// PORTS
//  clock        in   1          rising-edge clock
//  clear        in   1          synchronous, active-high reset
//  start        in   1          1-cycle request; operands and opcode sampled on this edge
//  opcode       in   5          operation select (table below)
//  Ry           in   WIDTH      operand A (dividend, multiplicand, shift source)
//  Rb           in   WIDTH      operand B (divisor, multiplier, shift amount)
//  busy         out  1          high from the cycle after an accepted start until done
//  done         out  1          1-cycle pulse; C_out and flags are valid from this cycle on
//  C_out        out  2*WIDTH    [WIDTH-1:0]=result/quotient/product lo; [2W-1:W]=remainder/product hi; else 0
//  overflow     out  1          ADD/ADDI/SUB signed overflow; 0 for all other ops
//  div_by_zero  out  1          DIV with Rb==0
//  illegal_op   out  1          opcode not in the table
// BEHAVIOUR
//  Opcodes: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001,
//   AND 01010, OR 01011, ADDI 01100 (=ADD), ANDI 01101 (=AND), ORI 01110 (=OR), MUL 01111,
//   DIV 10000, NEG 10001 (0-Ry), NOT 10010 (~Ry). Every opcode has a unique code.
//  Reset: state IDLE; busy=0, done=0, C_out=0, all flags 0; an in-flight op is abandoned, no done.
//  FSM: IDLE -> (start & single-cycle op) -> DONE; IDLE -> (start & MUL) -> MUL; IDLE -> (start & DIV) -> DIV;
//   MUL: WIDTH iterations, then -> DONE; DIV: WIDTH iterations, then -> FIX (sign correction) -> DONE;
//   DONE: done=1 for one cycle, then -> IDLE.
//  Latency (start sampled at edge t): single-cycle ops done at t+1; MUL at t+WIDTH+1; DIV at t+WIDTH+2.
//  start while busy or done=1: ignored; operands are not resampled; no error.
//  Operands are latched at start; Ry/Rb/opcode changes afterwards have no effect.
//  C_out and flags hold their value after done until the next accepted op's done cycle.
//  busy stays 0 and the FSM goes straight to DONE for single-cycle ops.
//  MUL: full 2W-bit two's-complement product; no overflow possible.
//  DIV: truncating division; quotient sign = sign(Ry)^sign(Rb); remainder takes the sign of Ry.
//   Rb==0: no iteration; finishes in single-cycle time (done at t+1), div_by_zero=1,
//   quotient = all ones, remainder = Ry. The case -2^(W-1)/-1 gives quotient -2^(W-1), remainder 0, no flag.
//  Shifts/rotates use the amount mod WIDTH (Rb upper bits ignored). SHRA fills with Ry[W-1].
//  Illegal opcode: completes as a single-cycle op, C_out=0, illegal_op=1.
//  Simultaneous clear and start: clear wins; the start is dropped.
// TESTING  (WIDTH=32)
//  ADD Ry=7FFFFFFF Rb=00000001 -> done at t+1; C_out=0000_0000_8000_0000; overflow=1
//  MUL Ry=FFFFFFFD Rb=00000007 -> busy for 32 cycles; done at t+33; C_out=FFFF_FFFF_FFFF_FFEB
//  DIV Ry=FFFFFFF9 (-7) Rb=2 -> done at t+34; C_out=FFFF_FFFF_FFFF_FFFD (r=-1, q=-3)
//  DIV Ry=5 Rb=0 -> done at t+1; div_by_zero=1; C_out=0000_0005_FFFF_FFFF
//  ROR Ry=00000001 Rb=00000021 -> C_out lo=80000000; SHRA Ry=80000000 Rb=4 -> C_out lo=F8000000
//  MUL start, clear at t+10, new ADD 2+3 started -> no done from MUL; ADD done at t+1 after its start; C_out=5

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative signed shift-add
// multiply and non-restoring signed divide, all reported through a registered done pulse.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     Ry,
  input  logic [WIDTH-1:0]     Rb,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   C_out,
  output logic                 overflow,
  output logic                 div_by_zero,
  output logic                 illegal_op
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH:0]     acc;     // MUL: partial product hi; DIV: partial remainder
  logic [WIDTH-1:0]   q;       // MUL: multiplier/product lo; DIV: dividend/quotient
  logic [WIDTH-1:0]   m;       // MUL: multiplicand; DIV: divisor magnitude
  logic               neg_q;
  logic               neg_r;

  // Single-cycle datapath, evaluated directly on the start operands
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff, ror_v, rol_v, abs_y, abs_b;
  logic [WIDTH-1:0]   sc_lo, sc_hi;
  logic               sc_ovf, sc_dbz, sc_ill;

  assign shamt = Rb[SHAMT_W-1:0];
  assign sum   = Ry + Rb;
  assign diff  = Ry - Rb;
  assign abs_y = Ry[WIDTH-1] ? -Ry : Ry;
  assign abs_b = Rb[WIDTH-1] ? -Rb : Rb;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      ror_v[i] = Ry[(i + int'(shamt)) % WIDTH];
      rol_v[i] = Ry[(i + WIDTH - int'(shamt)) % WIDTH];
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    sc_lo  = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: begin
        sc_lo  = sum;
        sc_ovf = (Ry[WIDTH-1] == Rb[WIDTH-1]) && (sum[WIDTH-1] != Ry[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo  = diff;
        sc_ovf = (Ry[WIDTH-1] != Rb[WIDTH-1]) && (diff[WIDTH-1] != Ry[WIDTH-1]);
      end
      OP_SHR:          sc_lo = Ry >> shamt;
      OP_SHRA:         sc_lo = $signed(Ry) >>> shamt;
      OP_SHL:          sc_lo = Ry << shamt;
      OP_ROR:          sc_lo = ror_v;
      OP_ROL:          sc_lo = rol_v;
      OP_AND, OP_ANDI: sc_lo = Ry & Rb;
      OP_OR, OP_ORI:   sc_lo = Ry | Rb;
      OP_NEG:          sc_lo = -Ry;
      OP_NOT:          sc_lo = ~Ry;
      OP_MUL:          ;
      OP_DIV: begin    // only reaches the outputs when Rb == 0
        sc_lo  = '1;
        sc_hi  = Ry;
        sc_dbz = 1'b1;
      end
      default:         sc_ill = 1'b1;
    endcase
  end

  // Signed shift-add step: the multiplier MSB carries negative weight, so the last step subtracts
  logic [WIDTH:0]   mul_addend, mul_sum, mul_acc_n;
  logic [WIDTH-1:0] mul_q_n;

  assign mul_addend = (cnt == LAST) ? -{m[WIDTH-1], m} : {m[WIDTH-1], m};
  assign mul_sum    = q[0] ? acc + mul_addend : acc;
  assign mul_acc_n  = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
  assign mul_q_n    = {mul_sum[0], q[WIDTH-1:1]};

  // Non-restoring step on magnitudes; signs are applied in the FIX state
  logic [WIDTH:0]   div_shift, div_acc_n;
  logic [WIDTH-1:0] div_q_n, rem_mag, quo_fix, rem_fix;

  assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign div_acc_n = acc[WIDTH] ? div_shift + {1'b0, m} : div_shift - {1'b0, m};
  assign div_q_n   = {q[WIDTH-2:0], ~div_acc_n[WIDTH]};
  assign rem_mag   = acc[WIDTH] ? acc[WIDTH-1:0] + m : acc[WIDTH-1:0];
  assign quo_fix   = neg_q ? -q : q;
  assign rem_fix   = neg_r ? -rem_mag : rem_mag;

  always_ff @(posedge clock) begin
    if (clear) begin
      // NOTE: every register, datapath included, is cleared so a run never starts from X.
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      C_out       <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            if (opcode == OP_MUL) begin
              state <= S_MUL;
              busy  <= 1'b1;
              acc   <= '0;
              m     <= Ry;
              q     <= Rb;
              cnt   <= '0;
            end else if (opcode == OP_DIV && Rb != '0) begin
              state <= S_DIV;
              busy  <= 1'b1;
              acc   <= '0;
              m     <= abs_b;
              q     <= abs_y;
              neg_q <= Ry[WIDTH-1] ^ Rb[WIDTH-1];
              neg_r <= Ry[WIDTH-1];
              cnt   <= '0;
            end else begin
              state       <= S_DONE;
              done        <= 1'b1;
              C_out       <= {sc_hi, sc_lo};
              overflow    <= sc_ovf;
              div_by_zero <= sc_dbz;
              illegal_op  <= sc_ill;
            end
          end
        end
        S_MUL: begin
          acc <= mul_acc_n;
          q   <= mul_q_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            C_out       <= {mul_acc_n[WIDTH-1:0], mul_q_n};
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
        S_DIV: begin
          acc <= div_acc_n;
          q   <= div_q_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          state       <= S_DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          C_out       <= {rem_fix, quo_fix};
          overflow    <= 1'b0;
          div_by_zero <= 1'b0;
          illegal_op  <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vector table, clear corner cases,
// and randomized operations checked against a plain-arithmetic reference model.
module tb_seq_alu;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [4:0]  opcode;
  logic [31:0] Ry, Rb;
  logic        busy, done, overflow, div_by_zero, illegal_op;
  logic [63:0] C_out;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .Ry(Ry), .Rb(Rb),
    .busy(busy), .done(done), .C_out(C_out), .overflow(overflow),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    logic        ovf;
    logic        dbz;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit signed arithmetic on the operation's definition
  function automatic vec_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    vec_t        v;
    longint      sa, sb, r, qq, rr;
    logic [63:0] aa, t64;
    logic [31:0] t32;
    int          s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    aa = {a, a};
    s  = int'(b[4:0]);
    v  = '0;
    v.op = op; v.a = a; v.b = b; v.lat = 1;
    case (op)
      5'd3, 5'd12: begin r = sa + sb; v.c = {32'd0, r[31:0]}; v.ovf = (r != longint'($signed(r[31:0]))); end
      5'd4:        begin r = sa - sb; v.c = {32'd0, r[31:0]}; v.ovf = (r != longint'($signed(r[31:0]))); end
      5'd5:        v.c = {32'd0, a >> s};
      5'd6:        begin t32 = $signed(a) >>> s; v.c = {32'd0, t32}; end
      5'd7:        v.c = {32'd0, a << s};
      5'd8:        begin t64 = aa >> s; v.c = {32'd0, t64[31:0]}; end
      5'd9:        begin t64 = aa << s; v.c = {32'd0, t64[63:32]}; end
      5'd10, 5'd13: v.c = {32'd0, a & b};
      5'd11, 5'd14: v.c = {32'd0, a | b};
      5'd15:       begin r = sa * sb; v.c = r; v.lat = 33; end
      5'd16: begin
        if (b == 32'd0) begin
          v.c = {a, 32'hFFFF_FFFF}; v.dbz = 1'b1;
        end else begin
          qq = sa / sb; rr = sa % sb;
          v.c = {rr[31:0], qq[31:0]}; v.lat = 34;
        end
      end
      5'd17:       begin r = -sa; v.c = {32'd0, r[31:0]}; end
      5'd18:       v.c = {32'd0, ~a};
      default:     v.ill = 1'b1;
    endcase
    return v;
  endfunction

  // Issue one op, optionally poke start while busy, then check timing, results and the done-cycle hold
  task automatic run_op(input vec_t v, input bit noise);
    int lat, busy_cnt;
    @(negedge clock);
    start = 1'b1; opcode = v.op; Ry = v.a; Rb = v.b;
    @(posedge clock); #1;
    start = 1'b0; opcode = 5'($urandom); Ry = $urandom; Rb = $urandom;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (noise && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1; opcode = 5'd3;
      end
      @(posedge clock); #1;
      start = 1'b0;
      lat++;
    end
    check($sformatf("latency op=%0d", v.op), 64'(lat), 64'(v.lat));
    check($sformatf("busy cycles op=%0d", v.op), 64'(busy_cnt), 64'(v.lat - 1));
    check($sformatf("busy at done op=%0d", v.op), 64'(busy), 64'd0);
    check($sformatf("C_out op=%0d a=%h b=%h", v.op, v.a, v.b), C_out, v.c);
    check($sformatf("flags op=%0d a=%h b=%h", v.op, v.a, v.b),
          64'({overflow, div_by_zero, illegal_op}), 64'({v.ovf, v.dbz, v.ill}));
    // start during the done cycle must be ignored and results must hold
    start = 1'b1; opcode = 5'd3; Ry = 32'd1; Rb = 32'd1;
    @(posedge clock); #1;
    start = 1'b0;
    check("done after ignored start", 64'(done), 64'd0);
    check("C_out hold", C_out, v.c);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    int dones;
    logic [4:0]  rop;
    logic [31:0] ra, rb;

    start = 1'b0; opcode = '0; Ry = '0; Rb = '0;
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset C_out", C_out, 64'd0);
    check("reset flags", 64'({overflow, div_by_zero, illegal_op}), 64'd0);
    clear = 1'b0;

    //            op     a             b             c                        ovf   dbz   ill   lat
    vecs.push_back('{5'd3,  32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd15, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0, 34});
    vecs.push_back('{5'd16, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{5'd8,  32'h0000_0001, 32'h0000_0021, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd6,  32'h8000_0000, 32'h0000_0004, 64'h0000_0000_F800_0000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd4,  32'h8000_0000, 32'h0000_0001, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd0,  32'h0000_1234, 32'h0000_0001, 64'h0,                   1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,                   1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0, 34});
    vecs.push_back('{5'd16, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0, 1'b0, 34});
    vecs.push_back('{5'd15, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{5'd18, 32'h0F0F_0F0F, 32'h0000_0000, 64'h0000_0000_F0F0_F0F0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd17, 32'h8000_0000, 32'h0000_0000, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd7,  32'h0000_0001, 32'h0000_0025, 64'h0000_0000_0000_0020, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd9,  32'h8000_0001, 32'h0000_0001, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd5,  32'hF000_0000, 32'h0000_0024, 64'h0000_0000_0F00_0000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd13, 32'hFF00_FF00, 32'h0FF0_0FF0, 64'h0000_0000_0F00_0F00, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd14, 32'hF000_0000, 32'h0000_000F, 64'h0000_0000_F000_000F, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd12, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0,                   1'b0, 1'b0, 1'b0, 1});

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i[0]);

    // clear during MUL abandons it; a later ADD completes normally
    @(negedge clock);
    start = 1'b1; opcode = 5'd15; Ry = 32'hFFFF_FFFD; Rb = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("clear mid-MUL busy", 64'(busy), 64'd0);
    check("clear mid-MUL C_out", C_out, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("no done from abandoned MUL", 64'(dones), 64'd0);
    run_op(model(5'd3, 32'd2, 32'd3), 1'b0);

    // simultaneous clear and start: clear wins
    @(negedge clock);
    clear = 1'b1; start = 1'b1; opcode = 5'd3; Ry = 32'd2; Rb = 32'd3;
    @(posedge clock); #1;
    clear = 1'b0; start = 1'b0;
    check("clear+start done", 64'(done), 64'd0);
    check("clear+start C_out", C_out, 64'd0);
    @(posedge clock); #1;
    check("clear+start no late done", 64'(done), 64'd0);

    // randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(3, 18));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'($urandom_range(0, 3));
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      v = model(rop, ra, rb);
      run_op(v, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
